// File: rtl/sync_ram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B.
// Every output is registered. A read returns on a per-requester data port two cycles after its grant.

module sync_ram_arbiter_chk (
  input logic clk,
  input logic rst,
  input logic gnt_a,
  input logic gnt_b,
  input logic rvalid_a,
  input logic rvalid_b,
  input logic ram_we,
  input logic busy
);

  a_gnt_onehot:   assert property (@(posedge clk) disable iff (rst) !(gnt_a && gnt_b));
  a_rvalid_excl:  assert property (@(posedge clk) disable iff (rst) !(rvalid_a && rvalid_b));
  a_we_with_gnt:  assert property (@(posedge clk) disable iff (rst) ram_we |-> (gnt_a || gnt_b));
  a_gnt_busy:     assert property (@(posedge clk) disable iff (rst) (gnt_a || gnt_b) |-> busy);
  a_rvalid_pulse: assert property (@(posedge clk) disable iff (rst) rvalid_a |=> !rvalid_a);

endmodule

module sync_ram_arbiter #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [DATA_W-1:0] din_a,
  output logic              gnt_a,
  output logic              rvalid_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic              req_b,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [DATA_W-1:0] din_b,
  output logic              gnt_b,
  output logic              rvalid_b,
  output logic [DATA_W-1:0] rdata_b,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  state_t              state_r;
  state_t              state_s;
  logic                last_gnt_r;
  logic                last_gnt_s;
  logic                owner_r;
  logic                owner_s;
  logic                win_b_s;
  logic                ram_we_s;
  logic [ADDR_W-1:0]   ram_addr_s;
  logic [DATA_W-1:0]   ram_din_s;
  logic                gnt_a_s;
  logic                gnt_b_s;
  logic                rvalid_a_s;
  logic                rvalid_b_s;
  logic [DATA_W-1:0]   rdata_a_s;
  logic [DATA_W-1:0]   rdata_b_s;
  logic                busy_s;

  // On a tie the requester that did not win last time goes first.
  function automatic logic pick_b(input logic ra, input logic rb, input logic last);
    if (ra && rb) begin
      return (last == SEL_A);
    end else begin
      return rb;
    end
  endfunction

  // Next-state and next-output computation for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    state_s    = state_r;
    last_gnt_s = last_gnt_r;
    owner_s    = owner_r;
    ram_we_s   = 1'b0;
    ram_addr_s = ram_addr;
    ram_din_s  = ram_din;
    gnt_a_s    = 1'b0;
    gnt_b_s    = 1'b0;
    rvalid_a_s = 1'b0;
    rvalid_b_s = 1'b0;
    rdata_a_s  = rdata_a;
    rdata_b_s  = rdata_b;
    win_b_s    = pick_b(req_a, req_b, last_gnt_r);

    case (state_r)
      IDLE: begin
        if (req_a || req_b) begin
          state_s    = ACCESS;
          last_gnt_s = win_b_s;
          owner_s    = win_b_s;
          if (win_b_s) begin
            ram_we_s   = we_b;
            ram_addr_s = addr_b;
            ram_din_s  = din_b;
            gnt_b_s    = 1'b1;
          end else begin
            ram_we_s   = we_a;
            ram_addr_s = addr_a;
            ram_din_s  = din_a;
            gnt_a_s    = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        // ram_we still holds the command type of the access in flight.
        if (ram_we) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      RESP: begin
        state_s = IDLE;
        if (owner_r == SEL_B) begin
          rdata_b_s  = ram_dout;
          rvalid_b_s = 1'b1;
        end else begin
          rdata_a_s  = ram_dout;
          rvalid_a_s = 1'b1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset clears everything and favours A on the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      last_gnt_r <= SEL_B;
      owner_r    <= SEL_A;
      ram_we     <= 1'b0;
      ram_addr   <= {ADDR_W{1'b0}};
      ram_din    <= {DATA_W{1'b0}};
      gnt_a      <= 1'b0;
      gnt_b      <= 1'b0;
      rvalid_a   <= 1'b0;
      rvalid_b   <= 1'b0;
      rdata_a    <= {DATA_W{1'b0}};
      rdata_b    <= {DATA_W{1'b0}};
      busy       <= 1'b0;
    end else begin
      state_r    <= state_s;
      last_gnt_r <= last_gnt_s;
      owner_r    <= owner_s;
      ram_we     <= ram_we_s;
      ram_addr   <= ram_addr_s;
      ram_din    <= ram_din_s;
      gnt_a      <= gnt_a_s;
      gnt_b      <= gnt_b_s;
      rvalid_a   <= rvalid_a_s;
      rvalid_b   <= rvalid_b_s;
      rdata_a    <= rdata_a_s;
      rdata_b    <= rdata_b_s;
      busy       <= busy_s;
    end
  end

  sync_ram_arbiter_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .gnt_a    (gnt_a),
    .gnt_b    (gnt_b),
    .rvalid_a (rvalid_a),
    .rvalid_b (rvalid_b),
    .ram_we   (ram_we),
    .busy     (busy)
  );

endmodule

// File: tb/tb_sync_ram_arbiter.sv
// Bench for sync_ram_arbiter: behavioural sync RAM on ram_*, scoreboard queues of expected read data.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.

module tb_sync_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_a, we_a, req_b, we_b;
  logic [1:0] addr_a, addr_b;
  logic [7:0] din_a, din_b;
  logic       gnt_a, rvalid_a, gnt_b, rvalid_b;
  logic [7:0] rdata_a, rdata_b;
  logic       ram_we;
  logic [1:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic       busy;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [7:0] exp_a_q[$];
  logic [7:0] exp_b_q[$];
  logic [7:0] mdl [4] = '{default: 8'h00};
  logic       mdl_last;
  logic [7:0] ram_mem [4] = '{default: 8'h00};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  sync_ram_arbiter #(.ADDR_W(2), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .din_a(din_a),
    .gnt_a(gnt_a), .rvalid_a(rvalid_a), .rdata_a(rdata_a),
    .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .din_b(din_b),
    .gnt_b(gnt_b), .rvalid_b(rvalid_b), .rdata_b(rdata_b),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
    .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
    req_a = r; we_a = w; addr_a = a; din_a = d;
  endtask

  task automatic drive_b(input logic r, input logic w, input logic [1:0] a, input logic [7:0] d);
    req_b = r; we_b = w; addr_b = a; din_b = d;
  endtask

  function automatic logic [7:0] pop_a();
    if (exp_a_q.size() > 0) return exp_a_q.pop_front();
    else return 8'hxx;
  endfunction

  function automatic logic [7:0] pop_b();
    if (exp_b_q.size() > 0) return exp_b_q.pop_front();
    else return 8'hxx;
  endfunction

  task automatic test_reset();
    logic [7:0] e;
    repeat (2) tick();
    total_cnt++;
    if ({gnt_a, gnt_b, rvalid_a, rvalid_b, rdata_a, rdata_b, ram_we, ram_addr, ram_din, busy} !== 29'd0)
      $display("FAIL reset_outputs: got nonzero outputs want all 0");
    else pass_cnt++;
    rst = 1'b0;
    drive_a(1'b1, 1'b1, 2'd2, 8'h77);
    tick();
    total_cnt++;
    if ({gnt_a, ram_we, busy} !== 3'b111) $display("FAIL pre_rst_access: got %b want 111", {gnt_a, ram_we, busy});
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({gnt_a, ram_we, busy} !== 3'b000) $display("FAIL rst_async: got %b want 000", {gnt_a, ram_we, busy});
    else pass_cnt++;
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    rst = 1'b0;
    mdl_last = 1'b1;
    // both request after reset: A must win the first tie
    drive_a(1'b1, 1'b0, 2'd0, 8'h00);
    drive_b(1'b1, 1'b0, 2'd1, 8'h00);
    exp_a_q.push_back(mdl[0]);
    tick();
    total_cnt++;
    if ({gnt_a, gnt_b} !== 2'b10) $display("FAIL first_tie: got %b want 10", {gnt_a, gnt_b});
    else pass_cnt++;
    mdl_last = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    drive_b(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    e = pop_a();
    total_cnt++;
    if ({rvalid_a, rvalid_b, rdata_a} !== {1'b1, 1'b0, e})
      $display("FAIL tie_read: got %b%b %h want 10 %h", rvalid_a, rvalid_b, rdata_a, e);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_write_seq();
    drive_a(1'b1, 1'b1, 2'd0, 8'hAA);
    mdl[0] = 8'hAA;
    tick();
    total_cnt++;
    if ({gnt_a, gnt_b, ram_we, ram_addr, ram_din} !== {3'b101, 2'd0, 8'hAA})
      $display("FAIL wr_a_cmd: got %b%b%b %h %h want 101 0 aa", gnt_a, gnt_b, ram_we, ram_addr, ram_din);
    else pass_cnt++;
    mdl_last = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    total_cnt++;
    if ({gnt_a, ram_we, busy} !== 3'b000) $display("FAIL wr_a_done: got %b want 000", {gnt_a, ram_we, busy});
    else pass_cnt++;
    drive_b(1'b1, 1'b1, 2'd1, 8'h55);
    mdl[1] = 8'h55;
    tick();
    total_cnt++;
    if ({gnt_a, gnt_b, ram_we, ram_addr, ram_din} !== {3'b011, 2'd1, 8'h55})
      $display("FAIL wr_b_cmd: got %b%b%b %h %h want 011 1 55", gnt_a, gnt_b, ram_we, ram_addr, ram_din);
    else pass_cnt++;
    mdl_last = 1'b1;
    drive_b(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    total_cnt++;
    if ({gnt_b, ram_we, busy, ram_addr} !== {3'b000, 2'd1})
      $display("FAIL wr_b_done: got %b %h want 000 1", {gnt_b, ram_we, busy}, ram_addr);
    else pass_cnt++;
  endtask

  task automatic test_read();
    logic [7:0] e;
    exp_a_q.push_back(mdl[0]);
    drive_a(1'b1, 1'b0, 2'd0, 8'h00);
    tick();
    total_cnt++;
    if ({gnt_a, gnt_b, ram_we} !== 3'b100) $display("FAIL rd_gnt: got %b want 100", {gnt_a, gnt_b, ram_we});
    else pass_cnt++;
    mdl_last = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    total_cnt++;
    if ({rvalid_a, busy} !== 2'b01) $display("FAIL rd_resp: got %b want 01", {rvalid_a, busy});
    else pass_cnt++;
    tick();
    e = pop_a();
    total_cnt++;
    if ({rvalid_a, rvalid_b, rdata_a, rdata_b} !== {2'b10, e, 8'h00})
      $display("FAIL rd_data: got %b%b %h %h want 10 %h 00", rvalid_a, rvalid_b, rdata_a, rdata_b, e);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({rvalid_a, rdata_a} !== {1'b0, e}) $display("FAIL rd_hold: got %b %h want 0 %h", rvalid_a, rdata_a, e);
    else pass_cnt++;
  endtask

  task automatic test_alternate();
    logic [7:0] e;
    int grants = 0;
    int nva = 0;
    int nvb = 0;
    repeat (2) exp_a_q.push_back(mdl[0]);
    repeat (2) exp_b_q.push_back(mdl[1]);
    drive_a(1'b1, 1'b0, 2'd0, 8'h00);
    drive_b(1'b1, 1'b0, 2'd1, 8'h00);
    for (int c = 0; c < 13; c++) begin
      tick();
      if (gnt_a || gnt_b) begin
        total_cnt++;
        if ({gnt_a, gnt_b} !== (mdl_last ? 2'b10 : 2'b01))
          $display("FAIL rr_order: got %b want %b", {gnt_a, gnt_b}, (mdl_last ? 2'b10 : 2'b01));
        else pass_cnt++;
        mdl_last = ~mdl_last;
        grants++;
        if (grants == 4) begin
          drive_a(1'b0, 1'b0, 2'd0, 8'h00);
          drive_b(1'b0, 1'b0, 2'd0, 8'h00);
        end
      end
      if (rvalid_a) begin
        e = pop_a();
        nva++;
        total_cnt++;
        if (rdata_a !== e) $display("FAIL rr_rdata_a: got %h want %h", rdata_a, e);
        else pass_cnt++;
      end
      if (rvalid_b) begin
        e = pop_b();
        nvb++;
        total_cnt++;
        if (rdata_b !== e) $display("FAIL rr_rdata_b: got %h want %h", rdata_b, e);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if ({grants[3:0], nva[3:0], nvb[3:0]} !== {4'd4, 4'd2, 4'd2})
      $display("FAIL rr_counts: got %0d/%0d/%0d want 4/2/2", grants, nva, nvb);
    else pass_cnt++;
  endtask

  task automatic test_wait();
    logic [7:0] e;
    exp_a_q.push_back(mdl[1]);
    drive_a(1'b1, 1'b0, 2'd1, 8'h00);
    tick();
    total_cnt++;
    if (gnt_a !== 1'b1) $display("FAIL wt_gnt_a: got %b want 1", gnt_a);
    else pass_cnt++;
    mdl_last = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    drive_b(1'b1, 1'b1, 2'd2, 8'hFF);
    mdl[2] = 8'hFF;
    tick();
    e = pop_a();
    total_cnt++;
    if ({rvalid_a, gnt_b, rdata_a, rdata_b} !== {2'b10, e, 8'h55})
      $display("FAIL wt_resp: got %b%b %h %h want 10 %h 55", rvalid_a, gnt_b, rdata_a, rdata_b, e);
    else pass_cnt++;
    tick();
    total_cnt++;
    if ({gnt_b, ram_we, ram_addr, ram_din} !== {2'b11, 2'd2, 8'hFF})
      $display("FAIL wt_gnt_b: got %b%b %h %h want 11 2 ff", gnt_b, ram_we, ram_addr, ram_din);
    else pass_cnt++;
    mdl_last = 1'b1;
    drive_b(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    exp_a_q.push_back(mdl[2]);
    drive_a(1'b1, 1'b0, 2'd2, 8'h00);
    tick();
    mdl_last = 1'b0;
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    e = pop_a();
    total_cnt++;
    if ({rvalid_a, rdata_a} !== {1'b1, e}) $display("FAIL wt_rd_ff: got %b %h want 1 %h", rvalid_a, rdata_a, e);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_access();
    logic [7:0] e;
    drive_a(1'b1, 1'b1, 2'd3, 8'h11);
    tick();
    total_cnt++;
    if ({gnt_a, ram_we} !== 2'b11) $display("FAIL ra_cmd: got %b want 11", {gnt_a, ram_we});
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({gnt_a, ram_we, busy, rdata_a, rdata_b} !== 19'd0)
      $display("FAIL ra_rst: got %b%b%b %h %h want 000 00 00", gnt_a, ram_we, busy, rdata_a, rdata_b);
    else pass_cnt++;
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    rst = 1'b0;
    mdl_last = 1'b1;
    exp_a_q.push_back(mdl[3]);
    drive_a(1'b1, 1'b0, 2'd3, 8'h00);
    tick();
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    tick();
    tick();
    e = pop_a();
    total_cnt++;
    if ({rvalid_a, rdata_a} !== {1'b1, e}) $display("FAIL ra_rd3: got %b %h want 1 %h", rvalid_a, rdata_a, e);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    drive_a(1'b0, 1'b0, 2'd0, 8'h00);
    drive_b(1'b0, 1'b0, 2'd0, 8'h00);
    test_reset();
    test_write_seq();
    test_read();
    test_alternate();
    test_wait();
    test_reset_access();
    total_cnt++;
    if (exp_a_q.size() + exp_b_q.size() != 0)
      $display("FAIL sb_empty: got %0d pending want 0", exp_a_q.size() + exp_b_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "timeout");
  end

endmodule
